// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite plotter and the logic that reuses its rotation.
//   DIR_*          orientation codes carried on the 2-bit direction bus
//   state_t        plotter FSM encoding
//   SCREEN_*_DEF   default visible screen size
package sprite_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLOT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;

endpackage

// File: rtl/sprite_rotate.sv
// Combinational sprite lookup: returns the mask bit shown at destination (r, c)
// for the requested orientation. The mask is stored in "up" orientation, with
// bit r*SPR_N+c holding row r, column c.
//   r, c       destination row / column
//   direction  orientation code (DIR_*)
//   mask       up-orientation bitmap
//   pix        selected bit
module sprite_rotate
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_N = 3
) (
  input  logic [((SPR_N > 1) ? $clog2(SPR_N) : 1)-1:0] r,
  input  logic [((SPR_N > 1) ? $clog2(SPR_N) : 1)-1:0] c,
  input  logic [1:0]                                   direction,
  input  logic [SPR_N*SPR_N-1:0]                       mask,
  output logic                                         pix
);

  localparam int unsigned CW = (SPR_N > 1) ? $clog2(SPR_N) : 1;
  localparam int unsigned IW = $clog2(SPR_N * SPR_N);
  localparam logic [CW-1:0] LAST = CW'(SPR_N - 1);

  logic [CW-1:0] sr;
  logic [CW-1:0] sc;
  logic [IW-1:0] idx;

  // Map destination coordinates back to the source cell of the up bitmap.
  always_comb begin
    sr = r;
    sc = c;
    case (direction)
      DIR_UP:    begin sr = r;        sc = c;        end
      DIR_DOWN:  begin sr = LAST - r; sc = LAST - c; end
      DIR_RIGHT: begin sr = LAST - c; sc = r;        end
      DIR_LEFT:  begin sr = c;        sc = LAST - r; end
      default:   begin sr = r;        sc = c;        end
    endcase
    idx = IW'(int'(sr) * int'(SPR_N) + int'(sc));
    pix = mask[idx];
  end

endmodule

// File: rtl/sprite_plotter.sv
// Plots an SPR_N x SPR_N monochrome sprite, one pixel per clock, into the VGA
// adapter write port. All draw inputs are captured when start is accepted.
// Optional screen-edge clipping is enabled by defining SPRITE_CLIP_EN.
//   CLOCK_50, resetn            clock, async active-low reset
//   start                       draw request (honoured in IDLE only)
//   x0, y0, direction           sprite origin and orientation
//   sprite_mask, erase          up-orientation bitmap; erase draws colour 0
//   colour_in                   draw colour
//   x, y, colour, plot          VGA write port
//   busy, done                  draw in progress / one-cycle completion pulse
module sprite_plotter
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_N    = 3,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [X_W-1:0]           x0,
  input  logic [Y_W-1:0]           y0,
  input  logic [1:0]               direction,
  input  logic [SPR_N*SPR_N-1:0]   sprite_mask,
  input  logic                     erase,
  input  logic [COLOUR_W-1:0]      colour_in,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [COLOUR_W-1:0]      colour,
  output logic                     plot,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CW = (SPR_N > 1) ? $clog2(SPR_N) : 1;
  localparam int unsigned MW = SPR_N * SPR_N;
  localparam logic [CW-1:0] LAST = CW'(SPR_N - 1);

`ifdef SPRITE_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  state_t                state;
  logic [CW-1:0]         r_q;
  logic [CW-1:0]         c_q;
  logic [X_W-1:0]        x0_q;
  logic [Y_W-1:0]        y0_q;
  logic [1:0]            dir_q;
  logic [MW-1:0]         mask_q;
  logic                  erase_q;
  logic [COLOUR_W-1:0]   colour_q;

  logic                  pix;
  logic [X_W:0]          xs;
  logic [Y_W:0]          ys;
  logic                  on_screen;

  sprite_rotate #(.SPR_N(SPR_N)) u_rotate (
    .r         (r_q),
    .c         (c_q),
    .direction (dir_q),
    .mask      (mask_q),
    .pix       (pix)
  );

  // Wide sums keep the carry so off-screen pixels can be detected before wrap.
  assign xs        = {1'b0, x0_q} + (X_W+1)'(c_q);
  assign ys        = {1'b0, y0_q} + (Y_W+1)'(r_q);
  assign on_screen = (xs < (X_W+1)'(SCREEN_W)) && (ys < (Y_W+1)'(SCREEN_H));

  // Scan FSM with registered pixel outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      r_q      <= '0;
      c_q      <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      dir_q    <= DIR_UP;
      mask_q   <= '0;
      erase_q  <= 1'b0;
      colour_q <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_PLOT;
            r_q      <= '0;
            c_q      <= '0;
            x0_q     <= x0;
            y0_q     <= y0;
            dir_q    <= direction;
            mask_q   <= sprite_mask;
            erase_q  <= erase;
            colour_q <= colour_in;
            busy     <= 1'b1;
          end
        end
        ST_PLOT: begin
          x      <= xs[X_W-1:0];
          y      <= ys[Y_W-1:0];
          colour <= erase_q ? '0 : colour_q;
          plot   <= pix & (on_screen | ~CLIP_EN);
          if (c_q == LAST) begin
            c_q <= '0;
            if (r_q == LAST) begin
              r_q   <= '0;
              state <= ST_DONE;
            end else begin
              r_q <= r_q + CW'(1);
            end
          end else begin
            c_q <= c_q + CW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
